// File: rtl/wishbone_memory_arbiter_pkg.sv
// Shared types and helpers for the Wishbone memory arbiter.
// State encoding, cycle-type constants and the index-width helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wishbone_memory_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the slave.
// slave modport = arbiter side; master modport = environment side.
interface wishbone_memory_arbiter_if #(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_BYTES    = 1
);

  logic [NUM_MASTERS-1:0]               m_cyc_i;
  logic [NUM_MASTERS-1:0]               m_stb_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i;
  logic [NUM_MASTERS*DATA_BYTES-1:0]    m_sel_i;
  logic [NUM_MASTERS*3-1:0]             m_cti_i;
  logic [DATA_WIDTH-1:0]                m_dat_o;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [NUM_MASTERS-1:0]               m_err_o;
  logic                                 s_cyc_o;
  logic                                 s_stb_o;
  logic                                 s_we_o;
  logic [ADDRESS_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]                s_dat_o;
  logic [DATA_BYTES-1:0]                s_sel_o;
  logic [2:0]                           s_cti_o;
  logic [DATA_WIDTH-1:0]                s_dat_i;
  logic                                 s_ack_i;
  logic [NUM_MASTERS-1:0]               gnt_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i,
    input  m_dat_i, m_sel_i, m_cti_i,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o,
    output s_dat_o, s_sel_o, s_cti_o, gnt_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i,
    output m_dat_i, m_sel_i, m_cti_i,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o,
    input  s_dat_o, s_sel_o, s_cti_o, gnt_o
  );

endinterface

// File: rtl/wishbone_memory_arbiter_rr_priority_picker.sv
// Round-robin picker: first requester above ptr_i, wrapping.
// Purely combinational; returns one-hot winner and its index.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!found && req_i[IW'(k)]) begin
        found           = 1'b1;
        gnt_o[IW'(k)]   = 1'b1;
        idx_o           = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wishbone_memory_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between masters.
// WB_ARB_TIMEOUT_EN adds a stall watchdog with err and RELEASE state.
module wishbone_memory_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk_i,
  input logic rst_ni,
  wishbone_memory_arbiter_if.slave bus
);

  localparam int IW = idx_w(NUM_MASTERS);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int DB = DATA_BYTES;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 1)
  begin : g_bad_param
    $error("wishbone_memory_arbiter: bad parameters");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pick_gnt;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          ptr_q, ptr_d, pick_idx;
  logic                   granted, own_cyc, tmo;
  int                     sel;

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i (bus.m_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign granted = (state_q == GRANT);
  assign own_cyc = bus.m_cyc_i[idx_q];
  assign sel     = int'(idx_q);

  assign bus.s_cyc_o = granted & own_cyc;
  assign bus.s_stb_o = granted & bus.m_stb_i[idx_q];
  assign bus.s_we_o  = granted & bus.m_we_i[idx_q];
  assign bus.s_adr_o = granted ? bus.m_adr_i[sel*AW +: AW] : '0;
  assign bus.s_dat_o = granted ? bus.m_dat_i[sel*DW +: DW] : '0;
  assign bus.s_sel_o = granted ? bus.m_sel_i[sel*DB +: DB] : '0;
  assign bus.s_cti_o = granted ? bus.m_cti_i[sel*3 +: 3] : '0;

  // Outside GRANT the slave's registered ack is swallowed here.
  assign bus.m_ack_o = (granted && bus.s_ack_i) ? gnt_q : '0;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = granted ? gnt_q : '0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;

  assign stall = granted & bus.s_stb_o & ~bus.s_ack_i;
  assign tmo   = stall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (stall && !tmo) ? cnt_q + 1'b1 : '0;

  assign bus.m_err_o = tmo ? gnt_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign tmo         = 1'b0;
  assign bus.m_err_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
        end
      end
      GRANT: begin
        if (tmo) begin
          state_d = RELEASE;
          ptr_d   = idx_q;
        end else if (!own_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = idx_q;
        end
      end
      RELEASE: begin
        // Stalled owner has let go; this cycle already isolated the slave.
        if (!own_cyc) begin
          if (|bus.m_cyc_i) begin
            state_d = GRANT;
            gnt_d   = pick_gnt;
            idx_d   = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_wishbone_memory_arbiter.sv
// Bench for wishbone_memory_arbiter: directed scenarios plus random
// traffic checked cycle by cycle against an ownership-level model.
module tb_wishbone_memory_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int DB = 1;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wishbone_memory_arbiter_if #(
    .NUM_MASTERS(N), .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW), .DATA_BYTES(DB)
  ) bus ();

  wishbone_memory_arbiter #(
    .NUM_MASTERS(N), .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW), .DATA_BYTES(DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  logic          mem_en, rnd_ack, mem_ack;
  logic [DW-1:0] rnd_dat, mem_rdat;
  logic [DW-1:0] mem [256];

  assign bus.s_ack_i = mem_en ? mem_ack : rnd_ack;
  assign bus.s_dat_i = mem_en ? mem_rdat : rnd_dat;

  // Single-port memory with one-cycle registered ack and read data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack <= 1'b0;
    end else begin
      mem_ack <= bus.s_cyc_o & bus.s_stb_o & ~mem_ack;
      if (bus.s_cyc_o & bus.s_stb_o & bus.s_we_o & ~mem_ack)
        mem[bus.s_adr_o[7:0]] <= bus.s_dat_o;
      mem_rdat <= mem[bus.s_adr_o[7:0]];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  tag, got, exp, $time);
  endtask

  // Model: who owns the slave, who spoke last, stall count.
  int owner, ptr, cnt;
  bit rel;

  task automatic model_reset();
    owner = -1;
    ptr   = N - 1;
    cnt   = 0;
    rel   = 1'b0;
  endtask

  function automatic bit mdl_err();
`ifdef WB_ARB_TIMEOUT_EN
    return owner >= 0 && !rel && bus.m_stb_i[owner]
           && !bus.s_ack_i && cnt == TO - 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic pick();
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (bus.m_cyc_i[k]) begin
        owner = k;
        break;
      end
    end
  endtask

  task automatic check_and_update();
    bit       g, e;
    int       o;
    logic [N-1:0] eg, ea, ee;
    g  = owner >= 0 && !rel;
    o  = g ? owner : 0;
    e  = mdl_err();
    eg = '0;
    ea = '0;
    ee = '0;
    if (g) eg[o] = 1'b1;
    if (g && bus.s_ack_i) ea[o] = 1'b1;
    if (e) ee[o] = 1'b1;
    chk("gnt", bus.gnt_o, eg);
    chk("s_cyc", bus.s_cyc_o, g ? bus.m_cyc_i[o] : 1'b0);
    chk("s_stb", bus.s_stb_o, g ? bus.m_stb_i[o] : 1'b0);
    chk("s_we", bus.s_we_o, g ? bus.m_we_i[o] : 1'b0);
    chk("s_adr", bus.s_adr_o, g ? bus.m_adr_i[o*AW +: AW] : '0);
    chk("s_dat", bus.s_dat_o, g ? bus.m_dat_i[o*DW +: DW] : '0);
    chk("s_cti", bus.s_cti_o, g ? bus.m_cti_i[o*3 +: 3] : '0);
    chk("m_ack", bus.m_ack_o, ea);
    chk("m_err", bus.m_err_o, ee);
    chk("m_dat", bus.m_dat_o, bus.s_dat_i);
    if (rel) begin
      if (!bus.m_cyc_i[owner]) begin
        rel   = 1'b0;
        owner = -1;
        pick();
      end
    end else if (owner < 0) begin
      pick();
    end else if (e) begin
      rel = 1'b1;
      ptr = owner;
      cnt = 0;
    end else if (!bus.m_cyc_i[owner]) begin
      ptr   = owner;
      owner = -1;
      cnt   = 0;
    end else begin
      cnt = (bus.m_stb_i[owner] && !bus.s_ack_i) ? cnt + 1 : 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input bit cyc, input bit stb,
                     input bit we, input logic [AW-1:0] adr,
                     input logic [DW-1:0] dat, input logic [2:0] cti);
    bus.m_cyc_i[m]           = cyc;
    bus.m_stb_i[m]           = stb;
    bus.m_we_i[m]            = we;
    bus.m_adr_i[m*AW +: AW]  = adr;
    bus.m_dat_i[m*DW +: DW]  = dat;
    bus.m_sel_i[m*DB +: DB]  = '1;
    bus.m_cti_i[m*3 +: 3]    = cti;
  endtask

  task automatic clear_all();
    for (int m = 0; m < N; m++) drv(m, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int m, input string tag);
    int n;
    n = 0;
    while (!bus.m_ack_o[m] && n < 8) begin
      step();
      n++;
    end
    chk(tag, bus.m_ack_o[m], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_all();
    mem_en  = 1'b1;
    rnd_ack = 1'b0;
    rnd_dat = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_gnt", bus.gnt_o, 2'b00);
    chk("rst_scyc", bus.s_cyc_o, 1'b0);
    chk("rst_ack", bus.m_ack_o, 2'b00);
    chk("rst_err", bus.m_err_o, 2'b00);

    // Single requester: write then read back through the memory.
    drv(0, 1, 1, 1, 16'h0010, 8'hA5, wb_arb_pkg::CTI_CLASSIC);
    step();
    chk("single_gnt", bus.gnt_o, 2'b01);
    chk("single_adr", bus.s_adr_o, 16'h0010);
    wait_ack(0, "wr_ack");
    drv(0, 0, 0, 0, '0, '0, '0);
    step();
    step();
    drv(0, 1, 1, 0, 16'h0010, 8'h00, wb_arb_pkg::CTI_CLASSIC);
    step();
    wait_ack(0, "rd_ack");
    chk("rd_data", bus.m_dat_o, 8'hA5);
    chk("rd_ack_only0", bus.m_ack_o, 2'b01);
    drv(0, 0, 0, 0, '0, '0, '0);
    step();
    step();

    // Contention and stale ack in the IDLE gap.
    mem_en = 1'b0;
    clear_all();
    do_reset();
    drv(0, 1, 1, 0, 16'h0100, 8'h00, '0);
    drv(1, 1, 1, 0, 16'h0200, 8'h00, '0);
    step();
    chk("cont_first", bus.gnt_o, 2'b01);
    rnd_ack = 1'b1;
    #1 chk("cont_ack0", bus.m_ack_o, 2'b01);
    step();
    drv(0, 0, 0, 0, '0, '0, '0);
    rnd_ack = 1'b0;
    #1 chk("drop_scyc", bus.s_cyc_o, 1'b0);
    step();
    rnd_ack = 1'b1;
    #1 chk("stale_ack", bus.m_ack_o, 2'b00);
    chk("idle_gap", bus.gnt_o, 2'b00);
    step();
    rnd_ack = 1'b0;
    #1 chk("cont_second", bus.gnt_o, 2'b10);
    chk("m1_no_early_ack", bus.m_ack_o, 2'b00);
    rnd_ack = 1'b1;
    #1 chk("m1_ack", bus.m_ack_o, 2'b10);
    step();
    drv(1, 0, 0, 0, '0, '0, '0);
    rnd_ack = 1'b0;
    step();
    drv(0, 1, 1, 0, 16'h0101, 8'h00, '0);
    drv(1, 1, 1, 0, 16'h0201, 8'h00, '0);
    step();
    chk("rr_again", bus.gnt_o, 2'b01);

    // Burst hold: master 1 keeps grant for all beats.
    rnd_ack = 1'b1;
    step();
    drv(0, 0, 0, 0, '0, '0, '0);
    rnd_ack = 1'b0;
    step();
    drv(0, 1, 1, 0, 16'h0102, 8'h00, '0);
    drv(1, 1, 1, 1, 16'h0300, 8'h11, wb_arb_pkg::CTI_INCR);
    step();
    for (int b = 0; b < 4; b++) begin
      drv(1, 1, 1, 1, 16'h0300 + 16'(b), 8'h11 + 8'(b),
          (b == 3) ? wb_arb_pkg::CTI_END : wb_arb_pkg::CTI_INCR);
      rnd_ack = 1'b1;
      #1 chk("burst_gnt", bus.gnt_o, 2'b10);
      chk("burst_adr", bus.s_adr_o, 16'h0300 + 16'(b));
      step();
    end
    drv(1, 0, 0, 0, '0, '0, '0);
    rnd_ack = 1'b0;
    step();
    step();
    chk("burst_after", bus.gnt_o, 2'b01);

    // Asynchronous reset in the middle of master 0's grant.
    rnd_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_gnt", bus.gnt_o, 2'b00);
    chk("mid_rst_scyc", bus.s_cyc_o, 1'b0);
    chk("mid_rst_ack", bus.m_ack_o, 2'b00);
    model_reset();
    clear_all();
    rnd_ack = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", bus.gnt_o, 2'b00);
    drv(0, 1, 1, 0, 16'h0040, 8'h00, '0);
    step();
    chk("post_rst_gnt", bus.gnt_o, 2'b01);
    clear_all();
    step();
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks master 0.
    do_reset();
    drv(0, 1, 1, 0, 16'h0050, 8'h00, '0);
    drv(1, 1, 1, 0, 16'h0060, 8'h00, '0);
    step();
    chk("tmo_gnt", bus.gnt_o, 2'b01);
    repeat (TO - 1) step();
    chk("tmo_err", bus.m_err_o, 2'b01);
    step();
    chk("tmo_rel_gnt", bus.gnt_o, 2'b00);
    chk("tmo_rel_err", bus.m_err_o, 2'b00);
    step();
    chk("tmo_rel_hold", bus.s_cyc_o, 1'b0);
    drv(0, 0, 0, 0, '0, '0, '0);
    step();
    chk("tmo_next", bus.gnt_o, 2'b10);
    clear_all();
    step();
    step();
`endif

    // Random traffic against the model.
    for (int c = 0; c < 700; c++) begin
      for (int m = 0; m < N; m++) begin
        bit cyc;
        cyc = bus.m_cyc_i[m];
        if (cyc)
          cyc = (c < 350) ? ($urandom_range(0, 5) != 0)
                          : ($urandom_range(0, 39) != 0);
        else
          cyc = ($urandom_range(0, 2) == 0);
        drv(m, cyc, 1'($urandom), 1'($urandom), AW'($urandom),
            DW'($urandom), 3'($urandom));
      end
      rnd_ack = (c < 350) ? 1'($urandom)
                          : ($urandom_range(0, 19) == 0);
      rnd_dat = DW'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wishbone_memory_arbiter.md
Name: wishbone_memory_arbiter

Overview:
- Shares one Wishbone slave, normally the on-chip wishbone_memory block, between NUM_MASTERS requesters, e.g. USB bridge, CPU and DMA.
- Round-robin grant, held for a master's whole cyc.
- Sits between the masters and the memory's single port.
- Discards the memory's trailing registered ack so it is never credited to the next master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- ADDRESS_WIDTH, 16, Wishbone address width.
- DATA_WIDTH, 8, Wishbone data width.
- DATA_BYTES, 1, select-line width.
- TIMEOUT_CYCLES, 16, watchdog limit; used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master we.
- m_adr_i  in  NUM_MASTERS*ADDRESS_WIDTH  packed addresses; master k at slice k.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_sel_i  in  NUM_MASTERS*DATA_BYTES  packed selects.
- m_cti_i  in  NUM_MASTERS*3  packed cycle-type identifiers.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master err; tied 0 without WB_ARB_TIMEOUT_EN.
- s_cyc_o, s_stb_o, s_we_o  out  1  to slave.
- s_adr_o  out  ADDRESS_WIDTH  to slave.
- s_dat_o  out  DATA_WIDTH  to slave.
- s_sel_o  out  DATA_BYTES  to slave.
- s_cti_o  out  3  to slave.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- gnt_o  out  NUM_MASTERS  one-hot current grant, for debug/status.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE, gnt_o=0, all s_* and m_ack_o/m_err_o low.
  - Priority pointer = NUM_MASTERS-1, so master 0 wins first.
  - Reset asserted mid-cycle aborts the transfer; no ack is delivered after reset.
- States:
  - IDLE: no grant.
  - GRANT: one master owns the slave.
- IDLE -> GRANT:
  - Taken on the clock edge where any m_cyc_i is high.
  - Winner is the first requester found scanning upward from pointer+1, modulo NUM_MASTERS.
  - gnt_o is registered, so slave signals appear 1 cycle after the request (arbitration latency = 1).
- In GRANT:
  - s_cyc_o/stb/we/adr/dat/sel/cti = granted master's inputs, combinational mux from gnt_o.
  - m_ack_o[g] = s_ack_i; other masters' acks = 0.
  - m_dat_o = s_dat_i at all times.
- GRANT -> IDLE:
  - Taken on the edge where the granted m_cyc_i is low.
  - Pointer := granted index.
  - s_cyc_o is already low combinationally in that cycle.
- Ack gating:
  - In IDLE all s_* outputs are 0 and every m_ack_o is 0, even if s_ack_i=1.
  - This absorbs the memory's ack, which is registered one cycle after cyc.
  - A new grant always spends ≥1 IDLE cycle, so a stale ack is never forwarded.
- Grant is never pre-empted while the owner holds cyc, including burst cti 3'b010 until cti 3'b111.
- Simultaneous events:
  - Owner dropping cyc in the same cycle another master raises cyc: go to IDLE first, grant the other master next cycle.
  - If the former owner re-requests in that same cycle, it ranks lowest.
- Non-granted masters see ack=0 and simply wait; no requirement on their stb.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) increments each GRANT cycle with s_stb_o=1 and s_ack_i=0, and clears on ack or IDLE.
  - On reaching TIMEOUT_CYCLES, m_err_o[g] pulses 1 cycle and the FSM forces IDLE; pointer advances past g.
  - Forced IDLE persists until the owner's m_cyc_i is seen low once (state RELEASE; slave signals 0).
- Undefined: no counter, no RELEASE state, m_err_o constant 0.

Decomposition:
- Package wb_arb_pkg:
  - State enum (IDLE, GRANT, RELEASE).
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111.
  - index-width helper function.
- One sub-module, rr_priority_picker: purely combinational; request vector + pointer -> one-hot winner + index.
- Arbiter FSM, muxes and watchdog stay in the top module.

Test Plan:
- Single requester: master 0 cyc/stb/we=1, adr=0x0010, dat=0xA5.
  - gnt_o=01 after 1 cycle, s_adr_o=0x0010.
  - A subsequent read of 0x0010 returns 0xA5 on m_dat_o, with ack only on m_ack_o[0].
- Contention: masters 0 and 1 raise cyc in the same cycle after reset.
  - Master 0 granted first.
  - On its cyc drop there is 1 IDLE cycle, then master 1 is granted.
  - Next simultaneous request goes to master 0 again (round-robin).
- Stale ack: memory acks 1 cycle after master 0 drops cyc while master 1 is waiting.
  - m_ack_o stays 00 in that cycle; master 1's first ack arrives only after its own access.
- Burst hold: master 1 issues a 4-beat cti=010/111 burst while master 0 requests continuously.
  - gnt_o stays 10 for all 4 beats, then switches.
- Reset mid-transfer: rst_ni pulsed low during master 0's GRANT.
  - All outputs go 0 immediately; after release, gnt_o=0 until a new cyc.
- (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) slave never acks master 0.
  - m_err_o[0] pulses at the 16th stalled cycle, state enters RELEASE.
  - Master 1 is granted 1 cycle after master 0 drops cyc.
